// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: shared player-input types and default timing at the 30 MHz logic clock
package tetris_input_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;
  typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_e;
  localparam int DEF_DEBOUNCE_CYCLES = 300000;
  localparam int DEF_DAS_DELAY_CYCLES = 5000000;
  localparam int DEF_DAS_REPEAT_CYCLES = 1500000;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchronizer followed by a consecutive-sample debouncer
module input_debouncer
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_sync <= '0;
      r_cnt <= '0;
      level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      if (r_sync[1] == level) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_cnt <= '0;
        level <= r_sync[1];
      end else r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounce, merge and pulse the player controls; INPUT_AUTOREPEAT_EN adds DAS repeat on left/right/down
module input_conditioner
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DAS_DELAY_CYCLES = DEF_DAS_DELAY_CYCLES,
  parameter int DAS_REPEAT_CYCLES = DEF_DAS_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_u,
  input  logic btn_d,
  input  logic btn_l,
  input  logic btn_r,
  input  logic pad_u,
  input  logic pad_d,
  input  logic pad_l,
  input  logic pad_r,
  output logic up,
  output logic down,
  output logic left,
  output logic right
);
  logic [3:0] w_btn, w_pad, w_btn_lvl, w_pad_lvl, w_held, w_eff, w_rise, w_pulse, r_prev;
  logic w_conf;
  genvar i;
  if (DEBOUNCE_CYCLES < 2 || DAS_DELAY_CYCLES < 2 || DAS_REPEAT_CYCLES < 2) begin : g_bad_params
    $error("input_conditioner: timing parameters must be >= 2");
  end
  assign w_btn = {btn_r, btn_l, btn_d, btn_u};
  assign w_pad = {pad_r, pad_l, pad_d, pad_u};
  for (i = 0; i < 4; i++) begin : g_deb
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(clk), .clr_n(clr_n), .raw(w_btn[i]), .level(w_btn_lvl[i])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pad (
      .clk(clk), .clr_n(clr_n), .raw(w_pad[i]), .level(w_pad_lvl[i])
    );
  end
  assign w_held = w_btn_lvl | w_pad_lvl;
  assign w_conf = w_held[DIR_L] & w_held[DIR_R];
  // a conflict masks both sides, so releasing one shows up as a fresh rise on the other
  assign w_eff = w_held & ~{w_conf, w_conf, 2'b00};
  assign w_rise = w_eff & ~r_prev;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_prev <= '0;
    else r_prev <= w_eff;
`ifdef INPUT_AUTOREPEAT_EN
  localparam int CW = $clog2(max2(DAS_DELAY_CYCLES, DAS_REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(DAS_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(DAS_REPEAT_CYCLES - 1);
  logic r_up;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_up <= 1'b0;
    else r_up <= w_rise[DIR_U];
  assign w_pulse[DIR_U] = r_up;
  for (i = 1; i < 4; i++) begin : g_das
    rep_state_e r_state;
    logic [CW-1:0] r_cnt;
    logic r_pulse;
    always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_pulse <= 1'b0;
      end else if (!w_eff[i]) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_pulse <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_pulse <= w_rise[i];
            r_cnt <= '0;
            if (w_rise[i]) r_state <= DELAY;
          end
          DELAY: begin
            r_pulse <= r_cnt == DLY_LAST;
            r_cnt <= r_cnt == DLY_LAST ? '0 : r_cnt + 1'b1;
            if (r_cnt == DLY_LAST) r_state <= REPEAT;
          end
          REPEAT: begin
            r_pulse <= r_cnt == REP_LAST;
            r_cnt <= r_cnt == REP_LAST ? '0 : r_cnt + 1'b1;
          end
          default: begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
          end
        endcase
      end
    assign w_pulse[i] = r_pulse;
  end
`else
  logic [3:0] r_pulse;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_pulse <= '0;
    else r_pulse <= w_rise;
  assign w_pulse = r_pulse;
`endif
  assign {right, left, down, up} = w_pulse;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner against a behavioural model
module tb_input_conditioner;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int REP = 3;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic [7:0] drv = '0;
  logic btn_u, btn_d, btn_l, btn_r, pad_u, pad_d, pad_l, pad_r;
  logic up, down, left, right;
  assign {pad_r, pad_l, pad_d, pad_u, btn_r, btn_l, btn_d, btn_u} = drv;
  always #5 clk = ~clk;
  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .DAS_DELAY_CYCLES(DLY), .DAS_REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .clr_n(clr_n),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .pad_u(pad_u), .pad_d(pad_d), .pad_l(pad_l), .pad_r(pad_r),
    .up(up), .down(down), .left(left), .right(right)
  );
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t0 = 0;
  int cnt[4];
  int lat[4];
  logic [7:0] m_s1, m_s2, m_lvl;
  logic [31:0] m_hist[8];
  logic [3:0] m_eff, m_eff_prev, m_exp;
  int m_age[4];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_lvl = '0;
    m_eff = '0;
    m_eff_prev = '0;
    m_exp = '0;
    for (int c = 0; c < 8; c++) m_hist[c] = '0;
    for (int d = 0; d < 4; d++) m_age[d] = 0;
  endtask
  // a debounced level flips once the last DEB synchronized samples all disagree with it
  task automatic model_step();
    logic [3:0] rise, held;
    logic [31:0] mask;
    rise = m_eff & ~m_eff_prev;
    m_exp = '0;
    m_exp[0] = rise[0];
    for (int d = 1; d < 4; d++) begin
      if (rise[d]) begin
        m_exp[d] = 1'b1;
        m_age[d] = 0;
      end else if (m_eff[d]) begin
        m_age[d]++;
`ifdef INPUT_AUTOREPEAT_EN
        m_exp[d] = (m_age[d] == DLY) || (m_age[d] > DLY && (m_age[d] - DLY) % REP == 0);
`endif
      end
    end
    m_eff_prev = m_eff;
    mask = (32'd1 << DEB) - 1;
    for (int c = 0; c < 8; c++) begin
      m_hist[c] = {m_hist[c][30:0], m_s2[c]};
      if ((m_hist[c] & mask) == (m_lvl[c] ? 32'd0 : mask)) m_lvl[c] = ~m_lvl[c];
    end
    m_s2 = m_s1;
    m_s1 = drv;
    held = m_lvl[3:0] | m_lvl[7:4];
    m_eff = (held[2] & held[3]) ? (held & 4'b0011) : held;
  endtask
  task automatic clear();
    t0 = cyc;
    for (int d = 0; d < 4; d++) begin
      cnt[d] = 0;
      lat[d] = -1;
    end
  endtask
  task automatic cycle();
    logic [3:0] got;
    @(posedge clk);
    if (clr_n) model_step();
    else model_reset();
    @(negedge clk);
    cyc++;
    got = {right, left, down, up};
    check($sformatf("out@%0d", cyc), {28'd0, got}, {28'd0, m_exp});
    for (int d = 0; d < 4; d++) begin
      cnt[d] += int'(got[d]);
      if (got[d] && lat[d] < 0) lat[d] = cyc - t0;
    end
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  task automatic async_reset(input string tag);
    clr_n = 1'b0;
    #1;
    check(tag, {28'd0, right, left, down, up}, 32'd0);
  endtask
  initial begin
    model_reset();
    clear();
    run(3);
    clr_n = 1'b1;
    run(3);
    clear();
    drv[0] = 1'b1;
    run(20);
    drv[0] = 1'b0;
    run(15);
    check("single_cnt", cnt[0], 1);
    check("single_lat", lat[0], 7);
    clear();
    for (int k = 0; k < 10; k++) begin
      drv[2] = ~drv[2];
      run(2);
    end
    drv[2] = 1'b0;
    run(10);
    check("bounce_cnt", cnt[2], 0);
    clear();
    drv[7] = 1'b1;
    run(30);
    drv[7] = 1'b0;
    run(15);
`ifdef INPUT_AUTOREPEAT_EN
    check("repeat_cnt", cnt[3], 8);
`else
    check("repeat_cnt", cnt[3], 1);
`endif
    check("repeat_lat", lat[3], 7);
    clear();
    drv[2] = 1'b1;
    run(15);
    drv[3] = 1'b1;
    run(8);
    clear();
    run(12);
    check("conflict_lr", cnt[2] + cnt[3], 0);
    drv[2] = 1'b0;
    clear();
    run(20);
    check("conflict_right_lat", lat[3], 7);
    check("conflict_left_cnt", cnt[2], 0);
    drv[3] = 1'b0;
    run(15);
    clear();
    drv[1] = 1'b1;
    drv[5] = 1'b1;
    run(5);
    drv[5] = 1'b0;
    run(4);
    drv[1] = 1'b0;
    run(15);
    check("merge_cnt", cnt[1], 1);
    clear();
    drv[3] = 1'b1;
    run(22);
    async_reset("rst_mid_repeat");
    run(3);
    clr_n = 1'b1;
    clear();
    run(25);
`ifdef INPUT_AUTOREPEAT_EN
    check("rst_repeat_cnt", cnt[3], 4);
`else
    check("rst_repeat_cnt", cnt[3], 1);
`endif
    check("rst_repeat_lat", lat[3], 7);
    drv[3] = 1'b0;
    run(15);
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 8; c++) if ($urandom_range(0, 15) == 0) drv[c] = ~drv[c];
      if (k == 700) begin
        async_reset("rst_random");
        run(2);
        clr_n = 1'b1;
      end
      cycle();
    end
    drv = '0;
    run(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
